alu_pipe: RTL



---
 rtl/alu_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 captures the operands and opcode. The result and N/Z/C/V flags are
// computed combinationally from S1 and registered into S2, which drives the
// outputs. An internal carry register (CF) chains multi-word ADD/SUB sequences.
// Optional build macro: ALU_PIPE_SIGNED_SLT_EN makes SLT a signed compare;
// without it, SLT compares unsigned.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPCODE,
  input  logic             Cin,
  input  logic             CSEL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  // WIDTH always fits in WIDTH bits because WIDTH >= 2.
  localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);

  // S1 stage registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_cin;
  logic             r_csel;
  // internal carry register used for chained ADD/SUB
  logic             r_cf;

  // handshake and datapath wires
  logic             w_adv;
  logic             w_accept;
  logic             w_move;
  logic             w_cin;
  logic             w_lt;
  logic             w_shift_big;
  logic             w_is_arith;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_v;

  // S2 can take a new entry when it is empty or being drained this cycle.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv;
  assign w_accept = in_valid && in_ready;
  assign w_move   = r_s1_valid && w_adv;

  // CF is read directly: an ADD/SUB that left S1 on the previous edge has
  // already written it, so back-to-back chaining needs no forwarding.
  assign w_cin       = r_csel ? r_cf : r_cin;
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_cin};
  assign w_shift_big = (r_b >= LP_WIDTH);
  assign w_is_arith  = (r_op == OP_ADD) || (r_op == OP_SUB);

`ifdef ALU_PIPE_SIGNED_SLT_EN
  assign w_lt = ($signed(r_a) < $signed(r_b));
`else
  assign w_lt = (r_a < r_b);
`endif

  // Combinational ALU: result, carry/borrow and overflow from the S1 contents.
  always_comb begin
    w_y = {WIDTH{1'b0}};
    w_c = 1'b0;
    w_v = 1'b0;
    case (r_op)
      OP_AND: w_y = r_a & r_b;
      OP_OR:  w_y = r_a | r_b;
      OP_XOR: w_y = r_a ^ r_b;
      OP_SRL: begin
        if (w_shift_big) begin
          w_y = {WIDTH{1'b0}};
        end else begin
          w_y = r_a >> r_b;
        end
      end
      OP_SLL: begin
        if (w_shift_big) begin
          w_y = {WIDTH{1'b0}};
        end else begin
          w_y = r_a << r_b;
        end
      end
      OP_SUB: begin
        w_y = w_diff[WIDTH-1:0];
        w_c = w_diff[WIDTH];
        w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_ADD: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLT: w_y = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
        w_y = {WIDTH{1'b0}};
        w_c = 1'b0;
        w_v = 1'b0;
      end
    endcase
  end

  // S1 capture: load on accept, empty when the held entry advances alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_op       <= 3'd0;
      r_cin      <= 1'b0;
      r_csel     <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_a        <= A;
      r_b        <= B;
      r_op       <= OPCODE;
      r_cin      <= Cin;
      r_csel     <= CSEL;
    end else if (w_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 output registers: load from the ALU on advance, drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= {WIDTH{1'b0}};
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else if (w_move) begin
      out_valid <= 1'b1;
      Y         <= w_y;
      N         <= w_y[WIDTH-1];
      Z         <= (w_y == {WIDTH{1'b0}});
      C         <= w_c;
      V         <= w_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Carry register: captures C of each ADD/SUB as it enters S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cf <= 1'b0;
    end else if (w_move && w_is_arith) begin
      r_cf <= w_c;
    end
  end

endmodule
